lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store controller that sits between the MEM pipeline stage and the data-memory port.
- Checks alignment of each load/store and issues a request/grant/response memory transaction.
- Generates store byte-enables and replicated write data; stalls the pipeline until the access completes.
- Returns the raw loaded word, right-aligned to byte 0, to the downstream load sign/zero-extension filter, which uses the same func3 encoding.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 64, max cycles spent in REQ+RESP before abort with bus_err; 0 disables the timeout.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, MEM stage holds a load/store.
- req_we, input, 1, 1=store, 0=load.
- req_func3, input, 3, RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- req_addr, input, ADDR_W, effective byte address.
- req_wdata, input, 32, rs2 store data.
- pipe_stall, output, 1, freeze pipeline.
- ld_data, output, 32, loaded word shifted right by addr[1:0]*8, to the load filter.
- ld_valid, output, 1, one-cycle pulse: ld_data updated.
- misalign, output, 1, one-cycle pulse: misaligned access rejected.
- bus_err, output, 1, one-cycle pulse: timeout abort.
- mem_req, output, 1, memory request.
- mem_we, output, 1, memory write.
- mem_addr, output, ADDR_W, word-aligned address (addr[1:0] forced to 00).
- mem_be, output, 4, active-high byte enables.
- mem_wdata, output, 32, write data.
- mem_gnt, input, 1, request accepted.
- mem_rvalid, input, 1, read data valid.
- mem_rdata, input, 32, read data.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - state=IDLE; all outputs 0, including ld_data, mem_addr, mem_be, mem_wdata.
  - Reset mid-transaction aborts it and drops mem_req immediately; no pulse is generated.
- Combinational stall: pipe_stall = req_valid && state!=DONE. The pipeline holds the req_* inputs stable while stalled.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, on req_valid, do the alignment check:
  - Half (func3[1:0]=01) needs addr[0]=0.
  - Word (10) needs addr[1:0]=00.
  - func3[1:0]=11 is illegal and is treated as misaligned.
  - Misaligned -> DONE with misalign pulsed in DONE; no memory access.
  - Aligned -> register mem_addr, mem_we, mem_be, mem_wdata; go to REQ.
- Store encoding:
  - sb: be=0001<<a, wdata={4{d[7:0]}}.
  - sh: be=0011<<a, wdata={2{d[15:0]}}.
  - sw: be=1111, wdata=d.
  - Here a=addr[1:0]. Loads set be=1111.
- REQ:
  - mem_req=1; mem_addr, mem_be, mem_wdata and mem_we stay stable until mem_gnt.
  - On gnt: store -> DONE; load -> RESP.
  - mem_req drops in the cycle after gnt.
- RESP:
  - Wait for mem_rvalid. Any mem_rvalid seen in REQ, or while no load is outstanding, is ignored.
  - On rvalid: ld_data <= mem_rdata >> (a*8), upper bits zero-filled; go to DONE.
- DONE:
  - Lasts exactly one cycle with pipe_stall=0.
  - ld_valid=1 only for a successfully completed load.
  - Then IDLE. The next request is accepted in IDLE the following cycle.
- Timeout:
  - Counter clears on entry to REQ and counts each REQ/RESP cycle.
  - When it reaches TIMEOUT (if nonzero): go to DONE with bus_err=1, ld_valid=0, ld_data unchanged.
- ld_data holds its value until the next successful load.
- misalign, bus_err and ld_valid are mutually exclusive.
- Minimum latency with gnt in the first REQ cycle and rvalid in the next cycle:
  - Load: accept cycle 0, REQ 1, RESP 2, DONE 3 — 3 stall cycles.
  - Store: 2 stall cycles.
- req_valid dropping while not in IDLE is illegal and is not checked.

Test Plan:
- lw addr=0x100, gnt in 1st REQ cycle, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, ld_data=0xDEADBEEF, ld_valid pulse in cycle 3, pipe_stall high for cycles 0-2.
- lb addr=0x203, rdata=0x80AABBCC -> mem_addr=0x200, ld_data=0x00000080, one ld_valid pulse.
- sh addr=0x302, wdata=0x1234ABCD, gnt delayed 3 cycles -> mem_req held 3 cycles with be=1100, wdata=0xABCDABCD, mem_addr=0x300 all stable; mem_we=1; no ld_valid.
- lw addr=0x101 and lh addr=0x103 -> misalign pulse each, mem_req never asserted, ld_data unchanged.
- TIMEOUT=8, lw with gnt never asserted -> after 8 REQ cycles bus_err pulses, pipe_stall drops, FSM returns to IDLE.
- rst_n low during RESP -> mem_req=0 and all outputs 0 asynchronously; after release, a new lw completes normally and a stale rvalid arriving before the new REQ is ignored.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : MEM-stage load/store controller: alignment check, req/gnt/rvalid
//            memory handshake, store byte-enables and pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              pipe_stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                 c_to_en    = (TIMEOUT != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_lane;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_misal;
  logic               r_berr;
  logic               r_ldok;

  logic               w_misal;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic               w_timeout;
  logic               w_accept;
  logic               w_misal_nxt;
  logic               w_berr_nxt;
  logic               w_ldok_nxt;

  // Sign/zero extension happens in the downstream load filter, so func3[2] is not needed here.
  logic               w_unused_f3;
  assign w_unused_f3 = req_func3[2];

  always_comb begin
    w_misal = 1'b0;
    case (req_func3[1:0])
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = req_addr[0];
      2'b10:   w_misal = |req_addr[1:0];
      default: w_misal = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        w_wdata = {4{req_wdata[7:0]}};
        if (req_we) w_be = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{req_wdata[15:0]}};
        if (req_we) w_be = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  assign w_timeout = c_to_en && (r_cnt == c_cnt_last);

  // Next-state and status outputs; a completing handshake wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_misal_nxt = 1'b0;
    w_berr_nxt  = 1'b0;
    w_ldok_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misal) begin
            w_state_nxt = S_DONE;
            w_misal_nxt = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
            w_accept    = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          w_state_nxt = mem_we ? S_DONE : S_RESP;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_berr_nxt  = 1'b1;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          w_state_nxt = S_DONE;
          w_ldok_nxt  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_berr_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    pipe_stall = req_valid && (r_state != S_DONE);
    mem_req    = (r_state == S_REQ);
    ld_valid   = (r_state == S_DONE) && r_ldok;
    misalign   = (r_state == S_DONE) && r_misal;
    bus_err    = (r_state == S_DONE) && r_berr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'd0;
      ld_data   <= 32'd0;
      r_lane    <= 2'd0;
      r_cnt     <= '0;
      r_misal   <= 1'b0;
      r_berr    <= 1'b0;
      r_ldok    <= 1'b0;
    end else begin
      if (w_accept) begin
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_we    <= req_we;
        mem_be    <= w_be;
        mem_wdata <= w_wdata;
        r_lane    <= req_addr[1:0];
      end
      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_RESP) && mem_rvalid) begin
        ld_data <= mem_rdata >> {r_lane, 3'b000};
      end
      if (w_state_nxt == S_DONE) begin
        r_misal <= w_misal_nxt;
        r_berr  <= w_berr_nxt;
        r_ldok  <= w_ldok_nxt;
      end
    end
  end

endmodule
`default_nettype wire
